// File: rtl/dm_access_pkg.sv
// Shared encodings for the data-memory access unit.
// Pure declarations; no logic, no latency.
// No flow control lives here.
package dm_access_pkg;

    // Request size encodings; 2'b11 is reserved and handled as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_e;

    // Byte and half stores need a read-merge-write; everything else is a word access.
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// CPU request/response and data-memory bus bundle for dm_access_unit.
// Wires only; no latency.
// The stall signal is the only backpressure: the requester holds req_* while it is high.
interface dm_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU side
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              misalign;
    // Data memory side
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_din;
    logic              dm_we;
    logic [DATA_W-1:0] dm_dout;

    // Outside world: CPU plus memory model.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_dout,
        input  stall, rdata, misalign, dm_addr, dm_din, dm_we
    );

    // The access unit itself.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_dout,
        output stall, rdata, misalign, dm_addr, dm_din, dm_we
    );
endinterface

// File: rtl/dm_byte_lane.sv
// Little-endian lane logic: load extraction/extension and store lane merge.
// Purely combinational, zero latency.
// No backpressure; callers decide when results are used.
import dm_access_pkg::*;

module dm_byte_lane (
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, extend it for loads and splice the store data into the old word.
    always_comb begin
        byte_sel = word_i[8*off_i +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = word_i;
        merge_o  = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o                = {{24{signed_i & byte_sel[7]}}, byte_sel};
                merge_o               = word_i;
                merge_o[8*off_i +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{signed_i & half_sel[15]}}, half_sel};
                merge_o = off_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                   : {word_i[31:16], wdata_i[15:0]};
            end
            default: begin
                // Word and the reserved encoding: whole word, low address bits ignored.
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Turns lb/lbu/lh/lhu/lw/sb/sh/sw into word accesses on a word-wide data memory.
// Loads and word stores: 0 cycles; byte/half stores: 2-cycle read-modify-write.
// Sub-word stores raise stall for one cycle; optional DM_MISALIGN_CHECK_EN flags misaligned accesses.
import dm_access_pkg::*;

module dm_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    dm_access_unit_if.slave bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] wbuf_q,  wbuf_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;

    logic [31:0] lane_load;
    logic [31:0] lane_merge;
    logic        misal;

    dm_byte_lane u_lane (
        .size_i   (bus.req_size),
        .signed_i (bus.req_signed),
        .off_i    (bus.req_addr[1:0]),
        .word_i   (bus.dm_dout),
        .wdata_i  (bus.req_wdata),
        .load_o   (lane_load),
        .merge_o  (lane_merge)
    );

`ifdef DM_MISALIGN_CHECK_EN
    // Flag halves on odd bytes and words off a word boundary; only new requests in IDLE count.
    always_comb begin
        misal = bus.req_valid && (state_q == ST_IDLE) &&
                (((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                 (!is_subword(bus.req_size) && (bus.req_addr[1:0] != 2'b00)));
    end
`else
    // Without the check, low address bits below the access size are simply ignored.
    always_comb begin
        misal = 1'b0;
    end
`endif

    assign bus.misalign = misal;

    // Next state and memory/CPU outputs; IDLE serves the live request, WRITE replays the merged word.
    always_comb begin
        state_d     = state_q;
        wbuf_d      = wbuf_q;
        waddr_d     = waddr_q;
        bus.dm_addr = bus.req_addr;
        bus.dm_din  = bus.req_wdata;
        bus.dm_we   = 1'b0;
        bus.stall   = 1'b0;
        bus.rdata   = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && !misal) begin
                    if (!bus.req_we) begin
                        bus.rdata = lane_load;
                    end else if (is_subword(bus.req_size)) begin
                        // Register the merge so the write happens from flops next cycle.
                        bus.stall = 1'b1;
                        wbuf_d    = lane_merge;
                        waddr_d   = bus.req_addr;
                        state_d   = ST_WRITE;
                    end else begin
                        bus.dm_we = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // Held request is ignored here; it is retired by this write.
                bus.dm_addr = waddr_q;
                bus.dm_din  = wbuf_q;
                bus.dm_we   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and write-buffer registers; reset abandons any pending sub-word store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wbuf_q  <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            wbuf_q  <= wbuf_d;
            waddr_q <= waddr_d;
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a behavioural 1024-word data memory.
// Load vectors are table-driven; RMW, reset and back-to-back cases are hand sequences.
// Build with DM_MISALIGN_CHECK_EN defined to exercise the misalignment flag.
module tb_dm_access_unit;

    localparam logic [1:0] B  = 2'b00;
    localparam logic [1:0] H  = 2'b01;
    localparam logic [1:0] W  = 2'b10;
    localparam logic [1:0] RS = 2'b11;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;

    dm_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dm_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: combinational read, synchronous word write.
    logic [31:0] mem [1024];
    assign bus.dm_dout = mem[bus.dm_addr[11:2]];
    always @(posedge clk) begin
        if (bus.dm_we) mem[bus.dm_addr[11:2]] <= bus.dm_din;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] exp_rdata;
    } load_vec_t;

    load_vec_t lv [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    task automatic idle_req();
        set_req(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
    endtask

    // Preload a memory word through a single-cycle word store.
    task automatic store_word(input logic [31:0] a, input logic [31:0] d);
        set_req(1'b1, 1'b1, W, 1'b0, a, d);
        tick();
        idle_req();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b1;
        idle_req();

        lv[0]  = '{"lb_0x32",   1'b1, B,  1'b1, 32'h32, 32'hFFFF_FFFF};
        lv[1]  = '{"lbu_0x33",  1'b1, B,  1'b0, 32'h33, 32'h0000_0080};
        lv[2]  = '{"lh_0x30",   1'b1, H,  1'b1, 32'h30, 32'h0000_7F01};
        lv[3]  = '{"lh_0x32",   1'b1, H,  1'b1, 32'h32, 32'hFFFF_80FF};
        lv[4]  = '{"lhu_0x32",  1'b1, H,  1'b0, 32'h32, 32'h0000_80FF};
        lv[5]  = '{"lb_0x30",   1'b1, B,  1'b1, 32'h30, 32'h0000_0001};
        lv[6]  = '{"lb_0x31",   1'b1, B,  1'b1, 32'h31, 32'h0000_007F};
        lv[7]  = '{"lbu_0x32",  1'b1, B,  1'b0, 32'h32, 32'h0000_00FF};
        lv[8]  = '{"lw_0x30",   1'b1, W,  1'b1, 32'h30, 32'h80FF_7F01};
        lv[9]  = '{"lrsv_0x30", 1'b1, RS, 1'b0, 32'h30, 32'h80FF_7F01};
        lv[10] = '{"novalid",   1'b0, W,  1'b0, 32'h30, 32'h0000_0000};
        lv[11] = '{"lhu_0x30",  1'b1, H,  1'b0, 32'h30, 32'h0000_7F01};

        // Reset state
        #2;
        check("rst_stall",    {31'b0, bus.stall},    32'h0);
        check("rst_we",       {31'b0, bus.dm_we},    32'h0);
        check("rst_rdata",    bus.rdata,             32'h0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Word store then word load
        set_req(1'b1, 1'b1, W, 1'b0, 32'h10, 32'hDEAD_BEEF);
        #1;
        check("sw_stall", {31'b0, bus.stall}, 32'h0);
        check("sw_we",    {31'b0, bus.dm_we}, 32'h1);
        check("sw_din",   bus.dm_din,         32'hDEAD_BEEF);
        check("sw_addr",  bus.dm_addr,        32'h10);
        check("sw_rdata", bus.rdata,          32'h0);
        tick();
        set_req(1'b1, 1'b0, W, 1'b0, 32'h10, 32'h0);
        #1;
        check("sw_mem",   mem[4],             32'hDEAD_BEEF);
        check("lw_rdata", bus.rdata,          32'hDEAD_BEEF);
        check("lw_stall", {31'b0, bus.stall}, 32'h0);
        check("lw_we",    {31'b0, bus.dm_we}, 32'h0);
        tick();

        // Byte store read-modify-write
        store_word(32'h20, 32'h1122_3344);
        set_req(1'b1, 1'b1, B, 1'b0, 32'h22, 32'h1234_56AA);
        #1;
        check("sb_c1_stall", {31'b0, bus.stall}, 32'h1);
        check("sb_c1_we",    {31'b0, bus.dm_we}, 32'h0);
        tick();
        check("sb_c2_stall", {31'b0, bus.stall}, 32'h0);
        check("sb_c2_we",    {31'b0, bus.dm_we}, 32'h1);
        check("sb_c2_din",   bus.dm_din,         32'h11AA_3344);
        check("sb_c2_addr",  bus.dm_addr,        32'h22);
        idle_req();
        tick();
        check("sb_mem",      mem[8],             32'h11AA_3344);
        check("sb_c3_stall", {31'b0, bus.stall}, 32'h0);
        check("sb_c3_we",    {31'b0, bus.dm_we}, 32'h0);

        // Table-driven loads from word 0x30
        store_word(32'h30, 32'h80FF_7F01);
        for (int i = 0; i < 12; i++) begin
            set_req(lv[i].valid, 1'b0, lv[i].size, lv[i].sgn, lv[i].addr, 32'h0);
            #1;
            check({lv[i].name, "_rdata"}, bus.rdata,          lv[i].exp_rdata);
            check({lv[i].name, "_stall"}, {31'b0, bus.stall}, 32'h0);
            check({lv[i].name, "_we"},    {31'b0, bus.dm_we}, 32'h0);
        end
        idle_req();
        tick();

        // Reset during the WRITE cycle of a half store
        store_word(32'h40, 32'h0);
        set_req(1'b1, 1'b1, H, 1'b0, 32'h40, 32'h0000_BEEF);
        #1;
        check("rmw_rst_c1_stall", {31'b0, bus.stall}, 32'h1);
        tick();
        check("rmw_rst_c2_we", {31'b0, bus.dm_we}, 32'h1);
        reset = 1'b1;
        #1;
        check("rmw_rst_we_drop", {31'b0, bus.dm_we}, 32'h0);
        set_req(1'b0, 1'b0, W, 1'b0, 32'h44, 32'h0);
        tick();
        check("rmw_rst_mem", mem[16], 32'h0);
        reset = 1'b0;
        #1;
        check("rmw_rst_idle_we",   {31'b0, bus.dm_we}, 32'h0);
        check("rmw_rst_idle_addr", bus.dm_addr,        32'h44);
        check("rmw_rst_idle_stall",{31'b0, bus.stall}, 32'h0);
        tick();
        check("rmw_rst_mem_after", mem[16], 32'h0);

        // Back-to-back sub-word stores into one word
        store_word(32'h50, 32'hCAFE_F00D);
        set_req(1'b1, 1'b1, H, 1'b0, 32'h50, 32'hFFFF_1234);
        #1;
        check("b2b_sh_c1_stall", {31'b0, bus.stall}, 32'h1);
        check("b2b_sh_c1_we",    {31'b0, bus.dm_we}, 32'h0);
        tick();
        check("b2b_sh_c2_we",    {31'b0, bus.dm_we}, 32'h1);
        check("b2b_sh_c2_din",   bus.dm_din,         32'hCAFE_1234);
        set_req(1'b1, 1'b1, B, 1'b0, 32'h51, 32'h0000_0056);
        #1;
        check("b2b_write_ignores_req", bus.dm_din, 32'hCAFE_1234);
        tick();
        check("b2b_sb_c1_stall", {31'b0, bus.stall}, 32'h1);
        check("b2b_sb_c1_we",    {31'b0, bus.dm_we}, 32'h0);
        check("b2b_mid_mem",     mem[20],            32'hCAFE_1234);
        tick();
        check("b2b_sb_c2_we",    {31'b0, bus.dm_we}, 32'h1);
        check("b2b_sb_c2_din",   bus.dm_din,         32'hCAFE_5634);
        check("b2b_sb_c2_addr",  bus.dm_addr,        32'h51);
        idle_req();
        tick();
        check("b2b_mem",         mem[20],            32'hCAFE_5634);

`ifdef DM_MISALIGN_CHECK_EN
        set_req(1'b1, 1'b0, W, 1'b0, 32'h06, 32'h0);
        #1;
        check("mis_lw_flag",  {31'b0, bus.misalign}, 32'h1);
        check("mis_lw_rdata", bus.rdata,             32'h0);
        set_req(1'b1, 1'b1, H, 1'b0, 32'h05, 32'h0000_1111);
        #1;
        check("mis_sh_flag",  {31'b0, bus.misalign}, 32'h1);
        check("mis_sh_stall", {31'b0, bus.stall},    32'h0);
        check("mis_sh_we",    {31'b0, bus.dm_we},    32'h0);
        set_req(1'b1, 1'b0, H, 1'b1, 32'h32, 32'h0);
        #1;
        check("mis_lh_ok_flag",  {31'b0, bus.misalign}, 32'h0);
        check("mis_lh_ok_rdata", bus.rdata,             32'hFFFF_80FF);
`else
        set_req(1'b1, 1'b0, W, 1'b0, 32'h32, 32'h0);
        #1;
        check("nomis_lw_flag",  {31'b0, bus.misalign}, 32'h0);
        check("nomis_lw_rdata", bus.rdata,             32'h80FF_7F01);
        set_req(1'b1, 1'b0, H, 1'b1, 32'h33, 32'h0);
        #1;
        check("nomis_lh_flag",  {31'b0, bus.misalign}, 32'h0);
        check("nomis_lh_rdata", bus.rdata,             32'hFFFF_80FF);
`endif
        idle_req();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
